// File: rtl/connect4_pkg.sv
// Shared constants and types for the connect-four move controller.
// Action vectors are {left, right, put}, with left in bit 2.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    localparam int LRP_LEFT  = 2;
    localparam int LRP_RIGHT = 1;
    localparam int LRP_PUT   = 0;

    typedef enum logic [1:0] {
        S_SELF = 2'd0,
        S_OPP  = 2'd1,
        S_DROP = 2'd2,
        S_FULL = 2'd3
    } state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic put;
    } lrp_t;

    // Reduce any action vector to a single action, left > right > put.
    function automatic lrp_t lrp_prio(input logic [2:0] bits);
        lrp_t r;
        r.left  = bits[LRP_LEFT];
        r.right = bits[LRP_RIGHT] & ~bits[LRP_LEFT];
        r.put   = bits[LRP_PUT] & ~bits[LRP_LEFT] & ~bits[LRP_RIGHT];
        return r;
    endfunction

endpackage

// File: rtl/col_heights.sv
// Per-column fill heights with a combinational read/full flag for one column
// and a single increment port.
module col_heights #(
    parameter int COLS = connect4_pkg::COLS,
    parameter int ROWS = connect4_pkg::ROWS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [$clog2(ROWS+1)-1:0] rd_height,
    output logic                      rd_full,
    input  logic                      inc_en,
    input  logic [$clog2(COLS)-1:0]   inc_col
);

    localparam int CW = $clog2(COLS);
    localparam int HW = $clog2(ROWS + 1);

    logic [COLS-1:0][HW-1:0] heights;

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            logic [HW-1:0] h_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    h_reg <= '0;
                end else if (inc_en && (inc_col == CW'(gi))) begin
                    h_reg <= h_reg + HW'(1);
                end
            end

            assign heights[gi] = h_reg;
        end
    endgenerate

    always_comb begin
        rd_height = '0;
        for (int i = 0; i < COLS; i++) begin
            if (rd_col == CW'(i)) begin
                rd_height = heights[i];
            end
        end
    end

    assign rd_full = (rd_height >= HW'(ROWS));

endmodule

// File: rtl/move_ctrl.sv
// Turn/cursor controller: accepts player actions, issues board writes and mirrors
// local actions to the link. Optional auto-move timer under `MOVE_TIMEOUT_EN.
module move_ctrl #(
    parameter int          COLS        = connect4_pkg::COLS,
    parameter int          ROWS        = connect4_pkg::ROWS,
    parameter logic        SELF_FIRST  = 1'b1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              lrp_self,
    input  logic [2:0]              lrp_opponent,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic                    self_turn,
    output logic                    wr_en,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic                    wr_player,
    output logic                    tx_left,
    output logic                    tx_right,
    output logic                    tx_put,
    output logic                    board_full
);

    import connect4_pkg::*;

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(ROWS * COLS + 1);

    localparam logic [CW-1:0] CUR_MAX   = CW'(COLS - 1);
    localparam logic [CW-1:0] CUR_INIT  = CW'(COLS / 2);
    localparam logic [MW-1:0] LAST_MOVE = MW'(ROWS * COLS - 1);

    state_t        state_reg;
    logic [CW-1:0] cursor_reg;
    logic [CW-1:0] wr_col_reg;
    logic [RW-1:0] wr_row_reg;
    logic          wr_player_reg;
    logic          wr_en_reg;
    logic          tx_left_reg;
    logic          tx_right_reg;
    logic          tx_put_reg;
    logic          board_full_reg;
    logic [MW-1:0] move_cnt_reg;

    logic [HW-1:0] cur_height;
    logic          cur_full;
    logic          auto_put;
    logic          auto_right;
    lrp_t          act;
    logic          is_self;
    logic          do_left;
    logic          do_right;
    logic          do_put;

    col_heights #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_heights (
        .clk       (clk),
        .rst       (rst),
        .rd_col    (cursor_reg),
        .rd_height (cur_height),
        .rd_full   (cur_full),
        .inc_en    (state_reg == S_DROP),
        .inc_col   (wr_col_reg)
    );

`ifdef MOVE_TIMEOUT_EN
    logic [31:0] timer_reg;
    logic        timeout;

    // Any local input in the timeout cycle takes precedence over the auto-move.
    assign timeout    = (state_reg == S_SELF) && (timer_reg >= TIMEOUT_CYC - 32'd1)
                        && (lrp_self == 3'b000);
    assign auto_put   = timeout && !cur_full;
    assign auto_right = timeout && cur_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg <= '0;
        end else if ((state_reg != S_SELF) || do_left || do_right || do_put) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign auto_put       = 1'b0;
    assign auto_right     = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // The current turn alone decides which source is listened to.
    always_comb begin
        act = '0;
        if (state_reg == S_SELF) begin
            act = lrp_prio(lrp_self | {1'b0, auto_right, auto_put});
        end else if (state_reg == S_OPP) begin
            act = lrp_prio(lrp_opponent);
        end
    end

    assign is_self  = (state_reg == S_SELF);
    assign do_left  = act.left;
    assign do_right = act.right;
    assign do_put   = act.put && !cur_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= SELF_FIRST ? S_SELF : S_OPP;
            cursor_reg     <= CUR_INIT;
            wr_col_reg     <= '0;
            wr_row_reg     <= '0;
            wr_player_reg  <= 1'b0;
            wr_en_reg      <= 1'b0;
            tx_left_reg    <= 1'b0;
            tx_right_reg   <= 1'b0;
            tx_put_reg     <= 1'b0;
            board_full_reg <= 1'b0;
            move_cnt_reg   <= '0;
        end else begin
            wr_en_reg    <= 1'b0;
            tx_left_reg  <= is_self && do_left;
            tx_right_reg <= is_self && do_right;
            tx_put_reg   <= is_self && do_put;
            case (state_reg)
                S_SELF, S_OPP: begin
                    if (do_left) begin
                        cursor_reg <= (cursor_reg == '0) ? CUR_MAX : cursor_reg - CW'(1);
                    end else if (do_right) begin
                        cursor_reg <= (cursor_reg == CUR_MAX) ? '0 : cursor_reg + CW'(1);
                    end else if (do_put) begin
                        state_reg     <= S_DROP;
                        wr_en_reg     <= 1'b1;
                        wr_col_reg    <= cursor_reg;
                        wr_row_reg    <= RW'(cur_height);
                        wr_player_reg <= is_self;
                    end
                end
                S_DROP: begin
                    // Height increments on this same edge inside col_heights.
                    move_cnt_reg <= move_cnt_reg + MW'(1);
                    if (move_cnt_reg == LAST_MOVE) begin
                        state_reg      <= S_FULL;
                        board_full_reg <= 1'b1;
                    end else begin
                        state_reg <= wr_player_reg ? S_OPP : S_SELF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cursor_col = cursor_reg;
    assign self_turn  = is_self;
    assign wr_en      = wr_en_reg;
    assign wr_col     = wr_col_reg;
    assign wr_row     = wr_row_reg;
    assign wr_player  = wr_player_reg;
    assign tx_left    = tx_left_reg;
    assign tx_right   = tx_right_reg;
    assign tx_put     = tx_put_reg;
    assign board_full = board_full_reg;

endmodule

// File: tb/tb_move_ctrl.sv
// Scoreboard bench for move_ctrl at default parameters (7x6, local player first).
module tb_move_ctrl;

    typedef struct packed {
        int col;
        int row;
        int player;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] lrp_self = 3'b000;
    logic [2:0] lrp_opponent = 3'b000;
    logic [2:0] cursor_col;
    logic       self_turn;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [2:0] wr_row;
    logic       wr_player;
    logic       tx_left;
    logic       tx_right;
    logic       tx_put;
    logic       board_full;

    int tests = 0;
    int fails = 0;

    wr_t        wr_q[$];
    logic [2:0] tx_q[$];

    // Reference state of the game as seen from the outside.
    int m_cur;
    int m_self;
    int m_moves;
    int m_full;
    int m_h[7];

    move_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .lrp_self     (lrp_self),
        .lrp_opponent (lrp_opponent),
        .cursor_col   (cursor_col),
        .self_turn    (self_turn),
        .wr_en        (wr_en),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_player    (wr_player),
        .tx_left      (tx_left),
        .tx_right     (tx_right),
        .tx_put       (tx_put),
        .board_full   (board_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        end
    endtask

    // Monitor: pops expected writes / link pulses whenever the DUT presents one.
    initial begin
        wr_t        e;
        logic [2:0] t;
        logic [2:0] tx_now;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wr_en) begin
                    tests++;
                    if (wr_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL wr_unexpected: got col=%0d row=%0d player=%0d, expected no write",
                                 wr_col, wr_row, wr_player);
                    end else begin
                        e = wr_q.pop_front();
                        if (wr_col !== 3'(e.col) || wr_row !== 3'(e.row) || wr_player !== 1'(e.player)) begin
                            fails++;
                            $display("[TB] FAIL wr_fields: got col=%0d row=%0d player=%0d, expected col=%0d row=%0d player=%0d",
                                     wr_col, wr_row, wr_player, e.col, e.row, e.player);
                        end else begin
                            $display("[TB] write col=%0d row=%0d player=%0d", wr_col, wr_row, wr_player);
                        end
                    end
                end
                tx_now = {tx_left, tx_right, tx_put};
                if (tx_now != 3'b000) begin
                    tests++;
                    if (tx_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL tx_unexpected: got tx=%b, expected none", tx_now);
                    end else begin
                        t = tx_q.pop_front();
                        if (tx_now !== t) begin
                            fails++;
                            $display("[TB] FAIL tx_bits: got tx=%b, expected %b", tx_now, t);
                        end else begin
                            $display("[TB] tx {left,right,put}=%b", tx_now);
                        end
                    end
                end
            end
        end
    end

    task automatic model_reset();
        m_cur   = 3;
        m_self  = 1;
        m_moves = 0;
        m_full  = 0;
        foreach (m_h[i]) m_h[i] = 0;
    endtask

    // Apply one action cycle; the reference decides which source counts.
    task automatic do_action(input logic [2:0] sb, input logic [2:0] ob);
        logic [2:0] src;
        int         exp_wr;
        exp_wr = 0;
        if (m_full == 0) begin
            src = (m_self != 0) ? sb : ob;
            if (src[2]) begin
                m_cur = (m_cur == 0) ? 6 : m_cur - 1;
                if (m_self != 0) tx_q.push_back(3'b100);
            end else if (src[1]) begin
                m_cur = (m_cur == 6) ? 0 : m_cur + 1;
                if (m_self != 0) tx_q.push_back(3'b010);
            end else if (src[0] && m_h[m_cur] < 6) begin
                exp_wr = 1;
                wr_q.push_back('{col: m_cur, row: m_h[m_cur], player: m_self});
                if (m_self != 0) tx_q.push_back(3'b001);
                m_h[m_cur]++;
                m_moves++;
                if (m_moves == 42) m_full = 1;
                else m_self = (m_self != 0) ? 0 : 1;
            end
        end
        @(negedge clk);
        lrp_self     = sb;
        lrp_opponent = ob;
        @(negedge clk);
        lrp_self     = 3'b000;
        lrp_opponent = 3'b000;
        check("wr_en_latency", 32'(wr_en), 32'(exp_wr));
        @(negedge clk);
        check("cursor_col", 32'(cursor_col), 32'(m_cur));
        check("self_turn", 32'(self_turn), 32'(m_self));
        check("board_full", 32'(board_full), 32'(m_full));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cursor", 32'(cursor_col), 32'd3);
        check("rst_self_turn", 32'(self_turn), 32'd1);
        check("rst_outputs", {19'd0, wr_en, wr_col, wr_row, wr_player, tx_left, tx_right, tx_put, board_full}, 32'd0);

        // First local put lands at column 3, row 0.
        do_action(3'b001, 3'b000);

        // Opponent steps right four times: 4, 5, 6, then wraps to 0.
        for (int i = 0; i < 4; i++) do_action(3'b000, 3'b010);
        check("wrap_cursor", 32'(cursor_col), 32'd0);

        // Six alternating puts fill column 0; the seventh is refused.
        for (int i = 0; i < 6; i++) do_action(3'b001, 3'b001);
        do_action(3'b001, 3'b001);
        check("full_col_turn", 32'(self_turn), 32'd0);

        // Opponent drops in column 1, then both sides act at once.
        do_action(3'b000, 3'b010);
        do_action(3'b000, 3'b001);
        do_action(3'b100, 3'b111);
        check("prio_cursor", 32'(cursor_col), 32'd0);
        do_action(3'b010, 3'b000);
        do_action(3'b001, 3'b000);
        do_action(3'b000, 3'b011);
        check("opp_011_cursor", 32'(cursor_col), 32'd2);

        // Fill the rest of the board column by column.
        for (int c = 0; c < 7; c++) begin
            if (m_full != 0) break;
            while (m_cur != c) do_action(3'b010, 3'b010);
            while (m_h[c] < 6 && m_full == 0) do_action(3'b001, 3'b001);
        end
        check("board_full_set", 32'(board_full), 32'd1);
        do_action(3'b001, 3'b001);
        do_action(3'b100, 3'b100);
        check("full_cursor_frozen", 32'(cursor_col), 32'd6);

        // Reset arriving while the drop is pending discards it.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        lrp_self = 3'b001;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        lrp_self = 3'b000;
        @(negedge clk);
        check("rst_drop_wr_en", 32'(wr_en), 32'd0);
        check("rst_drop_full", 32'(board_full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_action(3'b001, 3'b000);

        repeat (2) @(negedge clk);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
